// File: rtl/eeprom_seq.sv
// eeprom_seq: byte-write / random-read sequencer for a single-byte I2C EEPROM.
// Drives iic_ctrl start/stop/write/read pulses step by step and checks the slave
// ACK after every written byte.
// Optional feature: define ACK_POLL_EN to retry the transaction while the device
// NACKs its address (write-cycle polling), up to MAX_RETRY attempts.
module eeprom_seq #(
   parameter logic [6:0] DEV_ADDR   = 7'h50,
   parameter int         ADDR_BYTES = 1,
   parameter int         TIMEOUT    = 4095,
   parameter int         MAX_RETRY  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        rw,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic        i2c_start_en,
   output logic        i2c_stop_en,
   output logic        i2c_wr_en,
   output logic        i2c_rd_en,
   output logic [7:0]  i2c_din,
   output logic        i2c_ack_out,
   input  logic [7:0]  i2c_dout,
   input  logic        i2c_ack_in,
   input  logic        i2c_busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_DEVW, S_ADDRH, S_ADDRL, S_WDATA,
      S_RSTART, S_DEVR, S_RDATA, S_STOP
   } step_t;

   typedef enum logic [1:0] {PH_ISSUE, PH_WAIT_HI, PH_WAIT_LO} phase_t;

   // wide enough to reach TIMEOUT+1 without wrapping
   localparam int CW = $clog2(TIMEOUT + 2);

   step_t         step_q, step_n;
   phase_t        ph_q, ph_n;
   logic [CW-1:0] cnt_q;
   logic          rw_q;
   logic [15:0]   addr_q;
   logic [7:0]    wdata_q;

   logic accept, set_err, finish, latch_rd;
   logic wr_step, timed_out, hi_ok, lo_ok, nack_exit;
   logic poll_nack, retry_pend;

   assign wr_step   = (step_q == S_DEVW) || (step_q == S_ADDRH) || (step_q == S_ADDRL) ||
                      (step_q == S_WDATA) || (step_q == S_DEVR);
   assign timed_out = (cnt_q == CW'(TIMEOUT));
   assign hi_ok     = (ph_q == PH_WAIT_HI) && i2c_busy;
   assign lo_ok     = (ph_q == PH_WAIT_LO) && !i2c_busy;
   assign nack_exit = lo_ok && wr_step && i2c_ack_in;
   assign accept    = (step_q == S_IDLE) && req;

`ifdef ACK_POLL_EN
   localparam int RW = $clog2(MAX_RETRY + 1);
   logic [RW-1:0] retry_q;
   logic          retry_pend_q;

   // a DEVW NACK is retried unless this one would reach the retry limit
   assign poll_nack  = (step_q == S_DEVW) && ((int'(retry_q) + 1) < MAX_RETRY);
   assign retry_pend = retry_pend_q;

   // retry bookkeeping: count consecutive address NACKs, flag STOP to loop back
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retry_q      <= '0;
         retry_pend_q <= 1'b0;
      end else if (accept) begin
         retry_q      <= '0;
         retry_pend_q <= 1'b0;
      end else if (nack_exit && poll_nack) begin
         retry_q      <= retry_q + 1'b1;
         retry_pend_q <= 1'b1;
      end else if ((step_q == S_STOP) && (step_n != S_STOP)) begin
         retry_pend_q <= 1'b0;
      end
   end
`else
   assign poll_nack  = 1'b0;
   assign retry_pend = 1'b0;
`endif

   // next step/phase: ISSUE -> WAIT_HI -> WAIT_LO, with NACK and timeout exits
   always_comb begin
      step_n   = step_q;
      ph_n     = ph_q;
      set_err  = 1'b0;
      finish   = 1'b0;
      latch_rd = 1'b0;
      if (step_q == S_IDLE) begin
         ph_n = PH_ISSUE;
         if (req) step_n = S_START;
      end else if (ph_q == PH_ISSUE) begin
         ph_n = PH_WAIT_HI;
      end else if (hi_ok) begin
         ph_n = PH_WAIT_LO;
      end else if (lo_ok) begin
         ph_n = PH_ISSUE;
         if (nack_exit) begin
            step_n  = S_STOP;
            set_err = !poll_nack;
         end else begin
            case (step_q)
               S_START:  step_n = S_DEVW;
               S_DEVW:   step_n = (ADDR_BYTES == 2) ? S_ADDRH : S_ADDRL;
               S_ADDRH:  step_n = S_ADDRL;
               S_ADDRL:  step_n = rw_q ? S_RSTART : S_WDATA;
               S_WDATA:  step_n = S_STOP;
               S_RSTART: step_n = S_DEVR;
               S_DEVR:   step_n = S_RDATA;
               S_RDATA: begin
                  latch_rd = 1'b1;
                  step_n   = S_STOP;
               end
               S_STOP: begin
                  if (retry_pend) begin
                     step_n = S_START;
                  end else begin
                     step_n = S_IDLE;
                     finish = 1'b1;
                  end
               end
               default: step_n = S_IDLE;
            endcase
         end
      end else if (timed_out) begin
         // the bus is hung: try a STOP, or give up if STOP itself hung
         set_err = 1'b1;
         ph_n    = PH_ISSUE;
         if (step_q == S_STOP) begin
            step_n = S_IDLE;
            finish = 1'b1;
         end else begin
            step_n = S_STOP;
         end
      end
   end

   // state register, wait counter, host capture and result flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step_q  <= S_IDLE;
         ph_q    <= PH_ISSUE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata   <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         step_q <= step_n;
         ph_q   <= ph_n;
         cnt_q  <= (ph_q == PH_ISSUE) ? '0 : cnt_q + 1'b1;
         done   <= finish;
         if (accept) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
            err     <= 1'b0;
         end else if (set_err) begin
            err <= 1'b1;
         end
         if (latch_rd) rdata <= i2c_dout;
      end
   end

   // byte presented to iic_ctrl, constant for the whole step
   always_comb begin
      case (step_q)
         S_DEVW:  i2c_din = {DEV_ADDR, 1'b0};
         S_DEVR:  i2c_din = {DEV_ADDR, 1'b1};
         S_ADDRH: i2c_din = addr_q[15:8];
         S_ADDRL: i2c_din = addr_q[7:0];
         S_WDATA: i2c_din = wdata_q;
         default: i2c_din = 8'h00;
      endcase
   end

   assign busy         = (step_q != S_IDLE);
   assign i2c_start_en = (ph_q == PH_ISSUE) && ((step_q == S_START) || (step_q == S_RSTART));
   assign i2c_stop_en  = (ph_q == PH_ISSUE) && (step_q == S_STOP);
   assign i2c_wr_en    = (ph_q == PH_ISSUE) && wr_step;
   assign i2c_rd_en    = (ph_q == PH_ISSUE) && (step_q == S_RDATA);
   // single-byte reads always end with a master NACK
   assign i2c_ack_out  = 1'b1;

endmodule

// File: tb/tb_eeprom_seq.sv
// tb_eeprom_seq: vector table, random transactions against a byte-list model,
// and directed timeout / reset / busy-request / address-NACK sequences.
module tb_eeprom_seq;
   localparam logic [6:0] DEV = 7'h50;
   localparam int AB = 1;
   localparam int TO = 20;
   localparam int MR = 8;
   localparam logic [3:0] EV_S = 4'd1, EV_P = 4'd2, EV_W = 4'd3, EV_R = 4'd4;

   logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, rw = 1'b0;
   logic [15:0] addr = '0;
   logic [7:0]  wdata = '0;
   logic [7:0]  rdata, i2c_din;
   logic        done, err, busy, i2c_start_en, i2c_stop_en, i2c_wr_en, i2c_rd_en, i2c_ack_out;
   logic [7:0]  i2c_dout = '0;
   logic        i2c_ack_in = 1'b0, i2c_busy = 1'b0;

   eeprom_seq #(.DEV_ADDR(DEV), .ADDR_BYTES(AB), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
      .rdata(rdata), .done(done), .err(err), .busy(busy),
      .i2c_start_en(i2c_start_en), .i2c_stop_en(i2c_stop_en), .i2c_wr_en(i2c_wr_en),
      .i2c_rd_en(i2c_rd_en), .i2c_din(i2c_din), .i2c_ack_out(i2c_ack_out),
      .i2c_dout(i2c_dout), .i2c_ack_in(i2c_ack_in), .i2c_busy(i2c_busy));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0, wr_idx = 0, devw_nacks = 0, ackout_bad = 0;
   logic        done_err, done_busy;
   logic [7:0]  done_rdata;
   logic [11:0] ev_q[$], exp_q[$];
   int          ev_cyc[$];
   logic [31:0] nmask = '0;
   logic [7:0]  rbyte = '0;
   bit          stuck = 0, hold_long = 0, resp_active = 0;

   typedef struct {
      bit          rw;
      logic [15:0] addr;
      logic [7:0]  wd;
      logic [31:0] nmask;
      logic [7:0]  rbyte;
      bit          exp_err;
      logic [7:0]  exp_rdata;
   } vec_t;
   vec_t vt[6];

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // done monitor
   initial forever begin
      @(posedge clk); #1;
      if (done) begin
         done_cnt++;
         done_err = err; done_busy = busy; done_rdata = rdata;
      end
   end

   // iic_ctrl stand-in: log each pulse, then busy high for a while
   initial forever begin
      @(posedge clk); #1;
      if (i2c_start_en || i2c_stop_en || i2c_wr_en || i2c_rd_en) begin
         logic nack;
         int lat, dur;
         ev_q.push_back(i2c_start_en ? {EV_S, 8'h00} : i2c_stop_en ? {EV_P, 8'h00} :
                        i2c_wr_en ? {EV_W, i2c_din} : {EV_R, 8'h00});
         ev_cyc.push_back(cyc);
         if (i2c_rd_en && i2c_ack_out !== 1'b1) ackout_bad++;
         if (!stuck) begin
            nack = 1'b0;
            if (i2c_wr_en) begin
               if (i2c_din == {DEV, 1'b0} && devw_nacks > 0) begin
                  nack = 1'b1; devw_nacks--;
               end else if (wr_idx < 32) nack = nmask[wr_idx];
               wr_idx++;
            end
            lat = $urandom_range(1, 3);
            dur = hold_long ? 12 : $urandom_range(1, 4);
            resp_active = 1;
            repeat (lat) @(posedge clk);
            #1;
            i2c_busy = 1'b1; i2c_ack_in = nack; i2c_dout = rbyte;
            repeat (dur) @(posedge clk);
            #1;
            i2c_busy = 1'b0;
            resp_active = 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cmp_events(input string tag);
      check({tag, "_nev"}, ev_q.size(), exp_q.size());
      for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_ev%0d", tag, i), ev_q[i], exp_q[i]);
   endtask

   // reference: the bytes a transaction writes, cut short at the first NACK
   task automatic model(input bit r, input logic [15:0] a, input logic [7:0] d,
                        input logic [31:0] m, input logic [7:0] rb, input logic [7:0] prv,
                        output logic [7:0] nrd, output bit merr);
      logic [7:0] b[$];
      int k;
      exp_q.delete(); merr = 0; k = 0; nrd = prv;
      exp_q.push_back({EV_S, 8'h00});
      b.push_back({DEV, 1'b0});
      if (AB == 2) b.push_back(a[15:8]);
      b.push_back(a[7:0]);
      if (!r) b.push_back(d);
      foreach (b[i]) if (!merr) begin
         exp_q.push_back({EV_W, b[i]});
         if (m[k]) merr = 1;
         k++;
      end
      if (!merr && r) begin
         exp_q.push_back({EV_S, 8'h00});
         exp_q.push_back({EV_W, {DEV, 1'b1}});
         if (m[k]) merr = 1;
         else begin
            exp_q.push_back({EV_R, 8'h00});
            nrd = rb;
         end
      end
      exp_q.push_back({EV_P, 8'h00});
   endtask

   task automatic wait_done(input int start_dn, output int nd);
      int k;
      k = 0;
      while (done_cnt == start_dn && k < 3000) begin @(posedge clk); #2; k++; end
      k = 0;
      while (resp_active && k < 100) begin @(posedge clk); k++; end
      repeat (4) @(posedge clk);
      #2;
      nd = done_cnt - start_dn;
      @(negedge clk);
   endtask

   task automatic run_txn(input bit r, input logic [15:0] a, input logic [7:0] d, output int nd);
      int s;
      ev_q.delete(); ev_cyc.delete(); wr_idx = 0;
      @(negedge clk);
      rw = r; addr = a; wdata = d; req = 1'b1;
      s = done_cnt;
      @(negedge clk);
      req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
      wait_done(s, nd);
   endtask

   function automatic logic [23:0] outs();
      return {rdata, done, err, busy, i2c_start_en, i2c_stop_en, i2c_wr_en, i2c_rd_en,
              i2c_din, i2c_ack_out};
   endfunction

   initial begin
      int nd, s, gap;
      bit merr;
      logic [7:0] mrd;

      vt[0] = '{0, 16'h0032, 8'hC6, 32'h0, 8'h00, 0, 8'h00};
      vt[1] = '{1, 16'h0032, 8'h00, 32'h0, 8'h5A, 0, 8'h5A};
      vt[2] = '{0, 16'h0032, 8'hC6, 32'h2, 8'h00, 1, 8'h5A};
      vt[3] = '{1, 16'h0077, 8'h00, 32'h4, 8'h11, 1, 8'h5A};
      vt[4] = '{1, 16'h00A5, 8'h00, 32'h0, 8'hC3, 0, 8'hC3};
      vt[5] = '{0, 16'h00FF, 8'h3C, 32'h4, 8'h00, 1, 8'hC3};

      // reset state
      repeat (3) @(posedge clk);
      #1 check("reset_outs", outs(), 24'h000001);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 check("idle_outs", outs(), 24'h000001);

      mrd = 8'h00;
      for (int i = 0; i < 6; i++) begin
         nmask = vt[i].nmask; rbyte = vt[i].rbyte;
         model(vt[i].rw, vt[i].addr, vt[i].wd, vt[i].nmask, vt[i].rbyte, mrd, mrd, merr);
         run_txn(vt[i].rw, vt[i].addr, vt[i].wd, nd);
         check($sformatf("vec%0d_done", i), nd, 1);
         check($sformatf("vec%0d_err", i), done_err, vt[i].exp_err);
         check($sformatf("vec%0d_rdata", i), done_rdata, vt[i].exp_rdata);
         check($sformatf("vec%0d_busy", i), done_busy, 0);
         cmp_events($sformatf("vec%0d", i));
      end
      nmask = '0;

      // reset in the WDATA wait, with an ignored request just before it
      hold_long = 1; ev_q.delete(); wr_idx = 0;
      @(negedge clk);
      req = 1'b1; rw = 1'b0; addr = 16'h0044; wdata = 8'h99;
      @(negedge clk) req = 1'b0;
      s = 0;
      while (!(ev_q.size() == 4 && i2c_busy) && s < 500) begin @(posedge clk); #2; s++; end
      @(negedge clk);
      check("rst_busy_before", busy, 1);
      req = 1'b1; rw = 1'b1;
      s = done_cnt;
      @(negedge clk);
      req = 1'b0; rw = 1'b0; rst_n = 1'b0;
      @(posedge clk);
      #1 check("rst_outs", outs(), 24'h000001);
      @(negedge clk) rst_n = 1'b1;
      gap = ev_q.size();
      repeat (40) @(posedge clk);
      #2;
      check("rst_no_stop", ev_q.size(), gap);
      check("rst_no_done", done_cnt - s, 0);
      hold_long = 0; mrd = 8'h00;

      // request while busy is dropped
      model(0, 16'h0011, 8'h5E, 32'h0, 8'h00, mrd, mrd, merr);
      ev_q.delete(); wr_idx = 0;
      @(negedge clk);
      req = 1'b1; rw = 1'b0; addr = 16'h0011; wdata = 8'h5E;
      s = done_cnt;
      @(negedge clk) req = 1'b0;
      repeat (4) @(negedge clk);
      check("busyreq_busy", busy, 1);
      req = 1'b1; rw = 1'b1; addr = 16'h00EE;
      @(negedge clk);
      req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
      wait_done(s, nd);
      check("busyreq_done", nd, 1);
      check("busyreq_err", done_err, 0);
      cmp_events("busyreq");

      // random transactions against the model
      for (int i = 0; i < 40; i++) begin
         bit r;
         logic [15:0] a;
         logic [7:0] d;
         r = 1'($urandom_range(0, 1)); a = 16'($urandom); d = 8'($urandom);
         nmask = ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(1, 2)) : 32'd0;
         rbyte = 8'($urandom);
         model(r, a, d, nmask, rbyte, mrd, mrd, merr);
         run_txn(r, a, d, nd);
         check($sformatf("rnd%0d_done", i), nd, 1);
         check($sformatf("rnd%0d_err", i), done_err, merr);
         check($sformatf("rnd%0d_rdata", i), done_rdata, mrd);
         cmp_events($sformatf("rnd%0d", i));
      end
      nmask = '0;

      // iic_ctrl never raises busy: START times out, then STOP times out
      stuck = 1;
      run_txn(0, 16'h0012, 8'h34, nd);
      stuck = 0;
      check("to_done", nd, 1);
      check("to_err", done_err, 1);
      check("to_busy", done_busy, 0);
      exp_q.delete();
      exp_q.push_back({EV_S, 8'h00});
      exp_q.push_back({EV_P, 8'h00});
      cmp_events("to");
      if (ev_cyc.size() == 2) begin
         gap = ev_cyc[1] - ev_cyc[0];
         n_cmp++;
         if (gap < TO + 1 || gap > TO + 2) begin
            n_bad++;
            $display("FAIL to_gap: got %0d cycles expected %0d..%0d", gap, TO + 1, TO + 2);
         end
      end

`ifdef ACK_POLL_EN
      devw_nacks = 3;
      run_txn(0, 16'h0032, 8'hC6, nd);
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back({EV_S, 8'h00}); exp_q.push_back({EV_W, {DEV, 1'b0}}); exp_q.push_back({EV_P, 8'h00});
      end
      exp_q.push_back({EV_S, 8'h00}); exp_q.push_back({EV_W, {DEV, 1'b0}});
      exp_q.push_back({EV_W, 8'h32}); exp_q.push_back({EV_W, 8'hC6}); exp_q.push_back({EV_P, 8'h00});
      check("poll3_done", nd, 1);
      check("poll3_err", done_err, 0);
      cmp_events("poll3");
      devw_nacks = 8;
      run_txn(0, 16'h0032, 8'hC6, nd);
      exp_q.delete();
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back({EV_S, 8'h00}); exp_q.push_back({EV_W, {DEV, 1'b0}}); exp_q.push_back({EV_P, 8'h00});
      end
      check("poll8_done", nd, 1);
      check("poll8_err", done_err, 1);
      cmp_events("poll8");
      devw_nacks = 0;
`else
      devw_nacks = 1;
      run_txn(0, 16'h0032, 8'hC6, nd);
      exp_q.delete();
      exp_q.push_back({EV_S, 8'h00}); exp_q.push_back({EV_W, {DEV, 1'b0}}); exp_q.push_back({EV_P, 8'h00});
      check("devwnack_done", nd, 1);
      check("devwnack_err", done_err, 1);
      cmp_events("devwnack");
      devw_nacks = 0;
`endif

      check("ack_out_on_reads", ackout_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
